// File: rtl/axi_default_slave.sv
`default_nettype none
// ============================================================================
// axi_default_slave : AXI4 default responder, returns DECERR on B and R.
// Revision 1.0 - initial release
// ============================================================================
module axi_default_slave #(
  parameter int IDW = 4,
  parameter int DW  = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  // write address / data / response
  input  logic           i_awvalid,
  output logic           o_awready,
  input  logic [IDW-1:0] i_awid,
  input  logic           i_wvalid,
  output logic           o_wready,
  input  logic           i_wlast,
  output logic           o_bvalid,
  input  logic           i_bready,
  output logic [IDW-1:0] o_bid,
  output logic [1:0]     o_bresp,
  // read address / data
  input  logic           i_arvalid,
  output logic           o_arready,
  input  logic [IDW-1:0] i_arid,
  input  logic [7:0]     i_arlen,
  output logic           o_rvalid,
  input  logic           i_rready,
  output logic [IDW-1:0] o_rid,
  output logic [DW-1:0]  o_rdata,
  output logic [1:0]     o_rresp,
  output logic           o_rlast
);

  localparam logic [1:0] c_decerr = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  wr_state_t      r_wr_state;
  wr_state_t      w_wr_next;
  rd_state_t      r_rd_state;
  rd_state_t      w_rd_next;
  logic [IDW-1:0] r_bid;
  logic [IDW-1:0] r_rid;
  logic [7:0]     r_rcnt;
  logic           w_aw_hs;
  logic           w_ar_hs;
  logic           w_r_hs;

  assign w_aw_hs = i_awvalid && (r_wr_state == WR_IDLE);
  assign w_ar_hs = i_arvalid && (r_rd_state == RD_IDLE);
  assign w_r_hs  = i_rready  && (r_rd_state == RD_DATA);

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_state <= WR_IDLE;
    end else begin
      r_wr_state <= w_wr_next;
    end
  end

  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      WR_IDLE: if (i_awvalid)           w_wr_next = WR_DATA;
      // WLAST alone ends the burst; AWLEN is never consulted.
      WR_DATA: if (i_wvalid && i_wlast) w_wr_next = WR_RESP;
      WR_RESP: if (i_bready)            w_wr_next = WR_IDLE;
      default:                          w_wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bid <= '0;
    end else if (w_aw_hs) begin
      r_bid <= i_awid;
    end
  end

  // ----------------------------------------------------------------- read FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_state <= RD_IDLE;
    end else begin
      r_rd_state <= w_rd_next;
    end
  end

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (i_arvalid)                   w_rd_next = RD_DATA;
      RD_DATA: if (i_rready && (r_rcnt == 8'd0)) w_rd_next = RD_IDLE;
      default:                                  w_rd_next = RD_IDLE;
    endcase
  end

  // Counter holds beats remaining after the current one; stops at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rid  <= '0;
      r_rcnt <= 8'd0;
    end else if (w_ar_hs) begin
      r_rid  <= i_arid;
      r_rcnt <= i_arlen;
    end else if (w_r_hs && (r_rcnt != 8'd0)) begin
      r_rcnt <= r_rcnt - 8'd1;
    end
  end

  // ------------------------------------------------------------------ outputs
  assign o_awready = (r_wr_state == WR_IDLE);
  assign o_wready  = (r_wr_state == WR_DATA);
  assign o_bvalid  = (r_wr_state == WR_RESP);
  assign o_bid     = r_bid;
  assign o_bresp   = c_decerr;

  assign o_arready = (r_rd_state == RD_IDLE);
  assign o_rvalid  = (r_rd_state == RD_DATA);
  assign o_rid     = r_rid;
  assign o_rdata   = '0;
  assign o_rresp   = c_decerr;
  assign o_rlast   = (r_rd_state == RD_DATA) && (r_rcnt == 8'd0);

endmodule
`default_nettype wire

// File: doc/axi_default_slave.md
Name: axi_default_slave

Overview:
AXI4 responder that terminates every transaction the address decoder routes to the default slave, i.e. addresses that hit no mapped slave or a slave the master may not access. It accepts AW/W/AR traffic, drains write data, and returns DECERR on B and R with correct burst length and ID. It sits behind the interconnect's default-slave select, one instance per master port. Read and write channels are independent.

Parameters:
IDW, 4, AXI ID width (AWID/BID/ARID/RID)
DW, 32, read data width

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous, active-high reset
i_awvalid  input  1  write address valid
o_awready  output  1  write address ready
i_awid  input  IDW  write ID
i_wvalid  input  1  write data valid
o_wready  output  1  write data ready
i_wlast  input  1  last write beat
o_bvalid  output  1  write response valid
i_bready  input  1  write response ready
o_bid  output  IDW  write response ID
o_bresp  output  2  write response, always 2'b11
i_arvalid  input  1  read address valid
o_arready  output  1  read address ready
i_arid  input  IDW  read ID
i_arlen  input  8  read burst length minus 1
o_rvalid  output  1  read data valid
i_rready  input  1  read data ready
o_rid  output  IDW  read ID
o_rdata  output  DW  read data, always 0
o_rresp  output  2  read response, always 2'b11
o_rlast  output  1  last read beat

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst is asynchronous and active-high. All state flops reset asynchronously.
- Write FSM, states WR_IDLE, WR_DATA, WR_RESP. Reset state is WR_IDLE.
  - o_awready = (state==WR_IDLE); o_wready = (state==WR_DATA); o_bvalid = (state==WR_RESP). All are decoded from registered state, with no combinational path from any input.
  - WR_IDLE: on i_awvalid&&o_awready, capture i_awid and move to WR_DATA.
  - WR_DATA: accept and discard every beat. On i_wvalid&&i_wlast, move to WR_RESP. The beat count is not checked against AWLEN; WLAST alone terminates the burst.
  - WR_RESP: drive o_bid=captured ID and o_bresp=2'b11. Hold both stable until i_bready, then move to WR_IDLE.
  - W beats presented before the AW handshake stall, because o_wready=0 in WR_IDLE.
- Read FSM, states RD_IDLE, RD_DATA. Reset state is RD_IDLE.
  - o_arready = (state==RD_IDLE); o_rvalid = (state==RD_DATA).
  - RD_IDLE: on i_arvalid&&o_arready, capture i_arid into the RID register and i_arlen into an 8-bit down-counter, then move to RD_DATA.
  - RD_DATA: drive o_rdata=0, o_rresp=2'b11, o_rid=captured ID, and o_rlast=(counter==0).
  - On i_rready: if counter==0, move to RD_IDLE; otherwise decrement the counter.
  - Outputs hold stable while i_rready=0.
- Reset values:
  - o_awready=1, o_arready=1.
  - o_wready=0, o_bvalid=0, o_rvalid=0, o_rlast=0.
  - o_bid=0, o_rid=0, o_rdata=0, o_bresp=2'b11, o_rresp=2'b11.
- Latency:
  - AW handshake in cycle N gives o_wready=1 in N+1.
  - Final W beat in cycle M gives o_bvalid=1 in M+1.
  - AR handshake in cycle N gives the first R beat in N+1.
  - A burst of L=arlen+1 beats with i_rready held high completes in L cycles.
- Outstanding transactions: one per direction.
  - Each channel has one idle cycle between a completed transaction and the next address acceptance.
  - o_awready and o_arready reassert the cycle after B or last-R completes.
- Simultaneous events: AW and AR in the same cycle are both accepted; the two FSMs never interact.
- Boundary cases:
  - arlen=0 gives one beat with o_rlast=1.
  - arlen=255 gives 256 beats; the counter must not wrap.
  - wlast on the first W beat is legal and gives an immediate response.
- Reset mid-operation: both FSMs return to idle immediately. In-flight bursts are dropped, and no B or R is produced for them after reset.

Test Plan:
- Write, no backpressure: AW id=4'h5, 4 W beats with wlast on the 4th, bready=1 -> wready from cycle after AW; bvalid one cycle after the 4th beat; bid=5, bresp=2'b11 for exactly 1 cycle; awready returns the next cycle.
- Read burst, arlen=3: AR id=4'hA, rready=1 -> 4 consecutive beats starting the cycle after AR; rdata=0, rresp=2'b11, rid=A; rlast only on the 4th beat.
- Read with stalls: arlen=0, rready low for 5 cycles, then high -> rvalid=1 with rlast=1 held stable for 6 cycles; the handshake completes in the 6th; arready=1 the next cycle.
- Concurrent channels and B backpressure: AW id=1 and AR id=2 (arlen=255) in the same cycle; bready low 10 cycles -> both accepted; 256 R beats with rid=2 complete independently; bid=1 held until bready.
- W before AW: wvalid=1 with wlast=1, then AW 3 cycles later -> wready=0 until the cycle after AW; then a single-beat accept; bvalid follows.
- Reset mid-read: assert i_rst during beat 2 of an arlen=7 burst -> rvalid=0 and arready=1 immediately; no further R beats after reset release.
